// File: rtl/mac.sv
// rtl/mac.sv - UDP/IPv4/Ethernet II frame transmitter for a 100 Mb/s RMII PHY
module mac #(
  parameter logic [15:0] udp_my_port = 16'd11451,
  parameter logic [15:0] udp_port    = 16'd11452,
  parameter logic [31:0] src_ip_adr  = {8'd192, 8'd168, 8'd15, 8'd14},
  parameter logic [31:0] dst_ip_adr  = {8'd192, 8'd168, 8'd15, 8'd15},
  parameter logic [47:0] mac_adr     = 48'h0600AABB0CDD,
  parameter logic [47:0] mac_my_adr  = 48'hE86A64FAD17B
) (
  input  logic        I_clk50m,
  input  logic        I_rst,
  input  logic        I_en,
  input  logic [7:0]  I_data,
  input  logic [15:0] I_udpLen,
  input  logic [15:0] I_ipv4sign,
  output logic [1:0]  O_txd,
  output logic        O_txen,
  output logic        O_busy,
  output logic        O_isLoadData
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_PREAMBLE = 4'd1;
  localparam logic [3:0] S_ETH_HDR  = 4'd2;
  localparam logic [3:0] S_IP_HDR   = 4'd3;
  localparam logic [3:0] S_UDP_HDR  = 4'd4;
  localparam logic [3:0] S_PAYLOAD  = 4'd5;
  localparam logic [3:0] S_PAD      = 4'd6;
  localparam logic [3:0] S_FCS      = 4'd7;
  localparam logic [3:0] S_IFG      = 4'd8;

  // The line lags the sequencer by one register stage, so 48 IFG sequencer
  // cycles give exactly 48 line clocks with txen low before the next preamble.
  localparam logic [15:0] IFG_LAST = 16'd47;

  logic [3:0]   state;
  logic [15:0]  byte_cnt;
  logic [1:0]   dib;
  logic [15:0]  n_len;
  logic [15:0]  ip_id;
  logic [15:0]  ip_csum;
  logic [7:0]   data_reg;
  logic [31:0]  crc;

  logic [15:0]  total_len, udp_len, pad_len, csum_comb;
  logic [19:0]  csum_sum;
  logic [16:0]  csum_fold;
  logic [15:0]  csum_final;
  logic [111:0] eth_hdr, eth_sh;
  logic [159:0] ip_hdr, ip_sh;
  logic [63:0]  udp_hdr, udp_sh;
  logic [31:0]  fcs_sh;
  logic [7:0]   cur_byte, dib_sh;
  logic         active, last_byte, next_is_payload, ifg_done, start;
  logic [3:0]   after_state;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ (((r[0] ^ d[i]) == 1'b1) ? 32'hEDB88320 : 32'h0);
    end
    return r;
  endfunction

  assign total_len = n_len + 16'd28;
  assign udp_len   = n_len + 16'd8;
  assign pad_len   = (n_len < 16'd18) ? (16'd18 - n_len) : 16'd0;

  // Ones-complement sum of the nine non-checksum header words, two folds.
  assign csum_sum = 20'h04500 + 20'(total_len) + 20'(ip_id) + 20'h04000 + 20'h04011
                  + 20'(src_ip_adr[31:16]) + 20'(src_ip_adr[15:0])
                  + 20'(dst_ip_adr[31:16]) + 20'(dst_ip_adr[15:0]);
  assign csum_fold  = {1'b0, csum_sum[15:0]} + {13'b0, csum_sum[19:16]};
  assign csum_final = csum_fold[15:0] + {15'b0, csum_fold[16]};
  assign csum_comb  = ~csum_final;

  assign eth_hdr = {mac_adr, mac_my_adr, 16'h0800};
  assign ip_hdr  = {16'h4500, total_len, ip_id, 16'h4000, 16'h4011, ip_csum,
                    src_ip_adr, dst_ip_adr};
  assign udp_hdr = {udp_my_port, udp_port, udp_len, 16'h0000};
  assign eth_sh  = eth_hdr << {byte_cnt[3:0], 3'b000};
  assign ip_sh   = ip_hdr << {byte_cnt[4:0], 3'b000};
  assign udp_sh  = udp_hdr << {byte_cnt[2:0], 3'b000};
  assign fcs_sh  = (~crc) >> {byte_cnt[1:0], 3'b000};
  assign dib_sh  = cur_byte >> {dib, 1'b0};

  assign active   = (state >= S_PREAMBLE) && (state <= S_FCS);
  assign ifg_done = (state == S_IFG) && (byte_cnt == IFG_LAST);
  assign start    = I_en && ((state == S_IDLE) || ifg_done);
  assign next_is_payload = (dib == 2'd3) &&
                           (((state == S_UDP_HDR) && (byte_cnt == 16'd7) && (n_len != 16'd0)) ||
                            ((state == S_PAYLOAD) && (byte_cnt != n_len - 16'd1)));

  // Byte currently being serialised, its end-of-field flag and the field that follows.
  always_comb begin
    cur_byte    = 8'h00;
    last_byte   = 1'b0;
    after_state = S_IDLE;
    case (state)
      S_PREAMBLE: begin
        cur_byte    = (byte_cnt == 16'd7) ? 8'hD5 : 8'h55;
        last_byte   = (byte_cnt == 16'd7);
        after_state = S_ETH_HDR;
      end
      S_ETH_HDR: begin
        cur_byte    = eth_sh[111:104];
        last_byte   = (byte_cnt == 16'd13);
        after_state = S_IP_HDR;
      end
      S_IP_HDR: begin
        cur_byte    = ip_sh[159:152];
        last_byte   = (byte_cnt == 16'd19);
        after_state = S_UDP_HDR;
      end
      S_UDP_HDR: begin
        cur_byte    = udp_sh[63:56];
        last_byte   = (byte_cnt == 16'd7);
        after_state = (n_len != 16'd0) ? S_PAYLOAD : ((pad_len != 16'd0) ? S_PAD : S_FCS);
      end
      S_PAYLOAD: begin
        cur_byte    = (dib == 2'd0) ? I_data : data_reg;
        last_byte   = (byte_cnt == n_len - 16'd1);
        after_state = (pad_len != 16'd0) ? S_PAD : S_FCS;
      end
      S_PAD: begin
        cur_byte    = 8'h00;
        last_byte   = (byte_cnt == pad_len - 16'd1);
        after_state = S_FCS;
      end
      S_FCS: begin
        cur_byte    = fcs_sh[7:0];
        last_byte   = (byte_cnt == 16'd3);
        after_state = S_IFG;
      end
      default: begin
        cur_byte    = 8'h00;
        last_byte   = 1'b0;
        after_state = S_IDLE;
      end
    endcase
  end

  // Frame sequencer: field state, byte and dibit counters, latched request and CRC.
  always_ff @(posedge I_clk50m or negedge I_rst) begin
    if (!I_rst) begin
      state    <= S_IDLE;
      byte_cnt <= 16'd0;
      dib      <= 2'd0;
      n_len    <= 16'd0;
      ip_id    <= 16'd0;
      ip_csum  <= 16'd0;
      data_reg <= 8'h00;
      crc      <= 32'hFFFFFFFF;
    end else if (start) begin
      state    <= S_PREAMBLE;
      byte_cnt <= 16'd0;
      dib      <= 2'd0;
      n_len    <= I_udpLen;
      ip_id    <= I_ipv4sign;
      crc      <= 32'hFFFFFFFF;
    end else if (state == S_IFG) begin
      if (ifg_done) begin
        state    <= S_IDLE;
        byte_cnt <= 16'd0;
      end else begin
        byte_cnt <= byte_cnt + 16'd1;
      end
    end else if (active) begin
      dib <= dib + 2'd1;
      if (dib == 2'd3) begin
        if (last_byte) begin
          byte_cnt <= 16'd0;
          state    <= after_state;
        end else begin
          byte_cnt <= byte_cnt + 16'd1;
        end
      end
      if (state == S_PREAMBLE) ip_csum <= csum_comb;
      if ((state == S_PAYLOAD) && (dib == 2'd0)) data_reg <= I_data;
      if ((state >= S_ETH_HDR) && (state <= S_PAD) && (dib == 2'd0))
        crc <= crc_byte(crc, cur_byte);
    end
  end

  // Registered RMII pins and status strobes.
  always_ff @(posedge I_clk50m or negedge I_rst) begin
    if (!I_rst) begin
      O_txd        <= 2'b00;
      O_txen       <= 1'b0;
      O_busy       <= 1'b0;
      O_isLoadData <= 1'b0;
    end else begin
      O_txd        <= active ? dib_sh[1:0] : 2'b00;
      O_txen       <= active;
      O_busy       <= (state != S_IDLE);
      O_isLoadData <= active && next_is_payload;
    end
  end

endmodule

// File: tb/tb_mac.sv
// tb/tb_mac.sv - directed self-checking bench for the mac frame transmitter
module tb_mac;

  logic        I_clk50m = 1'b0;
  logic        I_rst;
  logic        I_en;
  logic [7:0]  I_data;
  logic [15:0] I_udpLen;
  logic [15:0] I_ipv4sign;
  logic [1:0]  O_txd;
  logic        O_txen;
  logic        O_busy;
  logic        O_isLoadData;

  int errors = 0;
  int checks = 0;

  logic [7:0] rx[$];
  logic [7:0] sent[$];
  int txen_clks, loads, spacing_bad, gap, busy_fell, timeout;
  logic [399:0] exp_hdr;
  logic [31:0]  c;
  int bad;

  mac dut (
    .I_clk50m     (I_clk50m),
    .I_rst        (I_rst),
    .I_en         (I_en),
    .I_data       (I_data),
    .I_udpLen     (I_udpLen),
    .I_ipv4sign   (I_ipv4sign),
    .O_txd        (O_txd),
    .O_txen       (O_txen),
    .O_busy       (O_busy),
    .O_isLoadData (O_isLoadData)
  );

  always #10 I_clk50m = ~I_clk50m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] cc, input logic [7:0] b);
    logic [31:0] r;
    r = cc;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
      else r = r >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] rxb(input int i);
    if (i < rx.size()) return rx[i];
    return 8'h00;
  endfunction

  task automatic pulse_en();
    @(negedge I_clk50m);
    I_en = 1'b1;
    @(negedge I_clk50m);
    I_en = 1'b0;
  endtask

  // Collects one frame off the pins, feeds I_data on each load strobe, then measures the gap.
  task automatic capture(input int data_mode, input int en_mode);
    int t;
    int last_load;
    int d;
    logic [7:0] acc;
    rx.delete();
    sent.delete();
    txen_clks = 0; loads = 0; spacing_bad = 0; gap = 0; busy_fell = 0; timeout = 0;
    last_load = -1; d = 0; acc = 8'h00; t = 0;
    while (!O_txen && t < 400) begin
      @(negedge I_clk50m);
      t++;
    end
    if (!O_txen) timeout = 1;
    while (O_txen && t < 20000) begin
      acc = {O_txd, acc[7:2]};
      d++;
      if (d % 4 == 0) rx.push_back(acc);
      if (O_isLoadData) begin
        if (last_load >= 0 && txen_clks - last_load != 4) spacing_bad++;
        last_load = txen_clks;
        loads++;
        I_data = (data_mode != 0) ? 8'hFF : 8'(loads * 37 + 5);
        sent.push_back(I_data);
      end
      if (en_mode == 1) begin
        if (txen_clks < 40) begin
          I_en = 1'($urandom_range(0, 1));
          I_udpLen = 16'($urandom_range(0, 600));
        end else begin
          I_en = 1'b0;
        end
      end
      txen_clks++;
      t++;
      @(negedge I_clk50m);
    end
    if (O_txen) timeout = 1;
    while (!O_txen && O_busy && gap < 200) begin
      gap++;
      @(negedge I_clk50m);
    end
    busy_fell = !O_busy;
  endtask

  task automatic check_crc(input string tag);
    int s;
    logic [31:0] r;
    s = rx.size();
    r = 32'hFFFFFFFF;
    for (int i = 8; i < s - 4; i++) r = crc_upd(r, rx[i]);
    r = ~r;
    chk({tag, "_fcs"}, {rxb(s - 1), rxb(s - 2), rxb(s - 3), rxb(s - 4)}, r);
    r = 32'hFFFFFFFF;
    for (int i = 8; i < s; i++) r = crc_upd(r, rx[i]);
    chk({tag, "_residue"}, r, 32'hDEBB20E3);
  endtask

  initial begin
    I_rst = 1'b0; I_en = 1'b0; I_data = 8'h00; I_udpLen = 16'd0; I_ipv4sign = 16'd0;
    repeat (3) @(negedge I_clk50m);
    chk("rst_txd", {30'b0, O_txd}, 32'd0);
    chk("rst_txen", {31'b0, O_txen}, 32'd0);
    chk("rst_busy", {31'b0, O_busy}, 32'd0);
    chk("rst_load", {31'b0, O_isLoadData}, 32'd0);
    I_rst = 1'b1;
    repeat (3) @(negedge I_clk50m);

    // Frame 1: N=0x01FF, ID=0x0123, patterned payload
    I_udpLen = 16'h01FF; I_ipv4sign = 16'h0123;
    pulse_en();
    capture(0, 0);
    chk("f1_timeout", timeout, 0);
    chk("f1_txen_clks", txen_clks, 2260);
    chk("f1_bytes", rx.size(), 565);
    exp_hdr = {56'h55555555555555, 8'hD5, 48'h0600AABB0CDD, 48'hE86A64FAD17B, 16'h0800,
               160'h4500021B0123400040119841C0A80F0EC0A80F0F, 64'h2CBB2CBC02070000};
    for (int i = 0; i < 50; i++) chk($sformatf("f1_hdr%0d", i), rxb(i), exp_hdr[399 - 8*i -: 8]);
    chk("f1_loads", loads, 511);
    chk("f1_spacing", spacing_bad, 0);
    bad = 0;
    for (int i = 0; i < 511; i++) if (i >= sent.size() || rxb(50 + i) !== sent[i]) bad++;
    chk("f1_payload", bad, 0);
    check_crc("f1");
    chk("f1_gap", gap, 48);
    chk("f1_busy_fell", busy_fell, 1);

    // Frame 2: N=4, constant 0xFF payload, 14 pad bytes
    repeat (5) @(negedge I_clk50m);
    I_udpLen = 16'd4; I_ipv4sign = 16'hBEEF;
    pulse_en();
    capture(1, 0);
    chk("f2_txen_clks", txen_clks, 288);
    chk("f2_loads", loads, 4);
    chk("f2_totlen", {rxb(24), rxb(25)}, 32'h0020);
    chk("f2_id", {rxb(26), rxb(27)}, 32'hBEEF);
    chk("f2_csum", {rxb(32), rxb(33)}, 32'hDC6F);
    chk("f2_udplen", {rxb(46), rxb(47)}, 32'h000C);
    chk("f2_payload", {rxb(50), rxb(51), rxb(52), rxb(53)}, 32'hFFFFFFFF);
    bad = 0;
    for (int i = 54; i < 68; i++) if (rxb(i) !== 8'h00) bad++;
    chk("f2_pad", bad, 0);
    check_crc("f2");
    chk("f2_gap", gap, 48);

    // Back-to-back: I_en held high, second frame toggles I_en and I_udpLen while busy
    repeat (5) @(negedge I_clk50m);
    I_udpLen = 16'd20; I_ipv4sign = 16'h0001;
    @(negedge I_clk50m);
    I_en = 1'b1;
    capture(0, 0);
    chk("b2b_a_txen_clks", txen_clks, 296);
    chk("b2b_a_gap", gap, 48);
    chk("b2b_a_busy_held", busy_fell, 0);
    check_crc("b2b_a");
    capture(0, 1);
    chk("b2b_b_txen_clks", txen_clks, 296);
    chk("b2b_b_loads", loads, 20);
    check_crc("b2b_b");
    chk("b2b_b_gap", gap, 48);
    chk("b2b_b_busy_fell", busy_fell, 1);
    I_udpLen = 16'd20;
    bad = 0;
    repeat (100) begin
      if (O_txen) bad++;
      @(negedge I_clk50m);
    end
    chk("b2b_no_extra", bad, 0);

    // Reset mid-payload, then a clean frame
    I_udpLen = 16'd100; I_ipv4sign = 16'h0042;
    pulse_en();
    bad = 0;
    while (!O_isLoadData && bad < 400) begin
      @(negedge I_clk50m);
      bad++;
    end
    chk("rst_reach_payload", {31'b0, O_isLoadData}, 32'd1);
    repeat (40) @(negedge I_clk50m);
    chk("pre_rst_txen", {31'b0, O_txen}, 32'd1);
    I_rst = 1'b0;
    @(negedge I_clk50m);
    chk("mid_rst_txd", {30'b0, O_txd}, 32'd0);
    chk("mid_rst_txen", {31'b0, O_txen}, 32'd0);
    chk("mid_rst_busy", {31'b0, O_busy}, 32'd0);
    chk("mid_rst_load", {31'b0, O_isLoadData}, 32'd0);
    repeat (3) @(negedge I_clk50m);
    I_rst = 1'b1;
    repeat (3) @(negedge I_clk50m);
    I_udpLen = 16'd30; I_ipv4sign = 16'h0043;
    pulse_en();
    capture(0, 0);
    chk("post_rst_timeout", timeout, 0);
    chk("post_rst_txen_clks", txen_clks, 336);
    chk("post_rst_loads", loads, 30);
    check_crc("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
